burst_master: RTL and testbench

Initiator side of the team's packed-field AXI-style burst bus: accepts single read or write commands from a local client and drives the address, data and response channels toward a memory slave. It sits between a client (processor model or test sequencer) and the 256-byte burst memory slave. It handles one transaction at a time, with full valid/ready handshaking on every channel.

---
 rtl/burst_master_if.sv | 50 +++++
 rtl/burst_master.sv | 132 +++++++++++++
 tb/tb_burst_master.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/burst_master_if.sv
// rtl/burst_master_if.sv - client and burst-bus signal bundle for burst_master
interface burst_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic [3:0]  cmd_id;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        rd_valid;
    logic        rd_last;
    logic        rd_ready;
    logic        done;
    logic        done_err;
    logic        ARVALID;
    logic        ARREADY;
    logic [15:0] IN;
    logic        RVALID;
    logic        RREADY;
    logic        RLAST;
    logic [8:0]  OUT;
    logic        AWVALID;
    logic        AWREADY;
    logic [11:0] AWIN;
    logic        WVALID;
    logic        WREADY;
    logic        WLAST;
    logic [7:0]  WDATA;
    logic        BVALID;
    logic        BREADY;
    logic [4:0]  BRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, wr_data, wr_valid, rd_ready,
               ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP,
        output cmd_ready, wr_ready, rd_data, rd_err, rd_valid, rd_last, done, done_err,
               ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, cmd_id, wr_data, wr_valid, rd_ready,
               ARREADY, RVALID, RLAST, OUT, AWREADY, WREADY, BVALID, BRESP,
        input  cmd_ready, wr_ready, rd_data, rd_err, rd_valid, rd_last, done, done_err,
               ARVALID, IN, RREADY, AWVALID, AWIN, WVALID, WLAST, WDATA, BREADY
    );
endinterface

// File: rtl/burst_master.sv
// rtl/burst_master.sv - single-outstanding read/write burst initiator
module burst_master (
    input  logic          clk,
    input  logic          rst,
    burst_master_if.master bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_AR   = 3'd1;
    localparam logic [2:0] S_R    = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;

    logic [2:0] state;
    logic [7:0] addr;
    logic [3:0] len;
    logic [3:0] id;
    logic [4:0] beats;
    logic       err;
    logic       started;
    logic       last_loaded;
    logic       wvalid_q;
    logic       wlast_q;
    logic [7:0] wdata_q;
    logic       done_q;
    logic       done_err_q;

    logic       in_r;
    logic       r_hs;
    logic       w_load;
    logic       w_hs;
    logic       wr_ready_i;
    logic [4:0] beats_nx;
    logic [4:0] exp_beats;

    assign in_r       = (state == S_R);
    assign r_hs       = in_r && bus.RVALID && bus.rd_ready;
    assign wr_ready_i = (state == S_W) && !last_loaded && (!wvalid_q || bus.WREADY);
    assign w_load     = wr_ready_i && bus.wr_valid;
    assign w_hs       = wvalid_q && bus.WREADY;
    assign beats_nx   = beats + 5'd1;
    assign exp_beats  = {1'b0, len} + 5'd1;

    // started keeps cmd_ready low until the first edge after reset release
    assign bus.cmd_ready = (state == S_IDLE) && started;
    assign bus.wr_ready  = wr_ready_i;
    assign bus.ARVALID   = (state == S_AR);
    assign bus.IN        = {addr, len, id};
    assign bus.AWVALID   = (state == S_AW);
    assign bus.AWIN      = {addr, id};
    assign bus.RREADY    = in_r && bus.rd_ready;
    assign bus.rd_data   = in_r ? bus.OUT[8:1] : 8'h00;
    assign bus.rd_err    = in_r && bus.OUT[0];
    assign bus.rd_valid  = in_r && bus.RVALID;
    assign bus.rd_last   = in_r && bus.RLAST;
    assign bus.WVALID    = wvalid_q;
    assign bus.WLAST     = wlast_q;
    assign bus.WDATA     = wdata_q;
    assign bus.BREADY    = (state == S_B);
    assign bus.done      = done_q;
    assign bus.done_err  = done_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            addr        <= 8'h00;
            len         <= 4'h0;
            id          <= 4'h0;
            beats       <= 5'd0;
            err         <= 1'b0;
            started     <= 1'b0;
            last_loaded <= 1'b0;
            wvalid_q    <= 1'b0;
            wlast_q     <= 1'b0;
            wdata_q     <= 8'h00;
            done_q      <= 1'b0;
            done_err_q  <= 1'b0;
        end else begin
            started    <= 1'b1;
            done_q     <= 1'b0;
            done_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid && started) begin
                        addr        <= bus.cmd_addr;
                        len         <= bus.cmd_len;
                        id          <= bus.cmd_id;
                        beats       <= 5'd0;
                        err         <= 1'b0;
                        last_loaded <= 1'b0;
                        state       <= bus.cmd_write ? S_AW : S_AR;
                    end
                end
                S_AR: if (bus.ARREADY) state <= S_R;
                S_R: begin
                    if (r_hs) begin
                        beats <= beats_nx;
                        err   <= err | bus.OUT[0];
                        if (bus.RLAST) begin
                            state      <= S_IDLE;
                            done_q     <= 1'b1;
                            done_err_q <= err | bus.OUT[0] | (beats_nx != exp_beats);
                        end
                    end
                end
                S_AW: if (bus.AWREADY) state <= S_W;
                S_W: begin
                    // a load may replace the beat handshaking this same cycle
                    if (w_load) begin
                        wdata_q  <= bus.wr_data;
                        wvalid_q <= 1'b1;
                        wlast_q  <= (beats[3:0] == len);
                        beats    <= beats_nx;
                        if (beats[3:0] == len) last_loaded <= 1'b1;
                    end else if (w_hs) begin
                        wvalid_q <= 1'b0;
                        wlast_q  <= 1'b0;
                    end
                    if (w_hs && wlast_q) state <= S_B;
                end
                S_B: begin
                    if (bus.BVALID) begin
                        state      <= S_IDLE;
                        done_q     <= 1'b1;
                        done_err_q <= err | bus.BRESP[4] | (bus.BRESP[3:0] != id);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_burst_master.sv
// tb/tb_burst_master.sv - scoreboard bench for burst_master with a memory slave model
module tb_burst_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    burst_master_if bif ();
    burst_master dut (.clk(clk), .rst(rst), .bus(bif));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  mem [256];
    logic [9:0]  sb_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic init_inputs();
        bif.cmd_valid = 0; bif.cmd_write = 0; bif.cmd_addr = 0; bif.cmd_len = 0; bif.cmd_id = 0;
        bif.wr_data = 0; bif.wr_valid = 0; bif.rd_ready = 0;
        bif.ARREADY = 0; bif.RVALID = 0; bif.RLAST = 0; bif.OUT = 0;
        bif.AWREADY = 0; bif.WREADY = 0; bif.BVALID = 0; bif.BRESP = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_outs"}, {bif.cmd_ready, bif.wr_ready, bif.rd_valid, bif.rd_last, bif.rd_err,
                               bif.done, bif.done_err, bif.ARVALID, bif.RREADY, bif.AWVALID,
                               bif.WVALID, bif.WLAST, bif.BREADY}, 0);
        check({tag, "_words"}, {bif.IN, bif.WDATA, bif.rd_data}, 0);
        check({tag, "_awin"}, {20'h0, bif.AWIN}, 0);
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [3:0] l, input logic [3:0] i);
        int t = 0;
        @(negedge clk);
        while (!bif.cmd_ready && t < 20) begin @(negedge clk); t++; end
        check("cmd_ready_idle", bif.cmd_ready, 1);
        bif.cmd_valid = 1; bif.cmd_write = w; bif.cmd_addr = a; bif.cmd_len = l; bif.cmd_id = i;
        @(negedge clk);
        bif.cmd_valid = 0;
        check("cmd_ready_busy", bif.cmd_ready, 0);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [3:0] l, input logic [3:0] i,
                            input logic [7:0] base, input bit stall, input logic [4:0] bresp, input bit exp_err);
        int wi = 0, popped = 0, stalls = 0, t = 0;
        bit fin = 0, pv = 0;
        logic [8:0] pw = 0;
        logic [9:0] e;
        issue(1, a, l, i);
        check("awvalid", bif.AWVALID, 1);
        check("awin", bif.AWIN, {a, i});
        repeat (2) begin
            @(negedge clk);
            check("awin_hold", {bif.AWVALID, bif.AWIN}, {1'b1, a, i});
            check("wvalid_early", bif.WVALID, 0);
        end
        bif.AWREADY = 1;
        @(negedge clk);
        bif.AWREADY = 0;
        check("awvalid_drop", bif.AWVALID, 0);
        check("wvalid_first", bif.WVALID, 0);
        while (!fin && t < 100) begin
            bif.wr_valid = 1;
            bif.wr_data  = 8'(base + wi);
            bif.WREADY   = !(stall && bif.WVALID && popped == 1 && stalls < 3);
            #1;
            if (pv) check("w_stable", {bif.WVALID, bif.WLAST, bif.WDATA}, {1'b1, pw});
            pv = bif.WVALID && !bif.WREADY;
            pw = {bif.WLAST, bif.WDATA};
            if (pv) stalls++;
            if (bif.wr_valid && bif.wr_ready) begin
                if (wi > l) check("wr_ready_after_last", 1, 0);
                else sb_q.push_back({1'b0, (wi == l), 8'(base + wi)});
                wi++;
            end
            if (bif.WVALID && bif.WREADY) begin
                if (sb_q.size() == 0) check("w_underflow", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    check("wbeat", {bif.WLAST, bif.WDATA}, e[8:0]);
                    mem[8'(a + popped)] = bif.WDATA;
                    popped++;
                    fin = bif.WLAST;
                end
            end
            @(negedge clk);
            t++;
        end
        bif.wr_valid = 0; bif.WREADY = 0;
        check("w_finished", fin, 1);
        check("w_beats", popped, l + 1);
        if (stall) check("w_stall_cycles", stalls, 3);
        check("bready", {bif.BREADY, bif.wr_ready, bif.done}, 3'b100);
        bif.BVALID = 1; bif.BRESP = bresp;
        @(negedge clk);
        bif.BVALID = 0;
        check("w_done", {bif.done, bif.done_err, bif.cmd_ready}, {1'b1, exp_err, 1'b1});
        @(negedge clk);
        check("w_done_pulse", bif.done, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [3:0] l, input logic [3:0] i,
                           input int nb, input logic [15:0] errmask, input bit toggle, input bit exp_err);
        int bi = 0, pushed = -1, popped = 0, t = 0;
        bit fin = 0;
        logic [9:0] e;
        issue(0, a, l, i);
        check("arvalid", bif.ARVALID, 1);
        check("in_word", bif.IN, {a, l, i});
        @(negedge clk);
        check("in_hold", {bif.ARVALID, bif.IN}, {1'b1, a, l, i});
        bif.ARREADY = 1;
        @(negedge clk);
        bif.ARREADY = 0;
        check("arvalid_drop", bif.ARVALID, 0);
        while (!fin && t < 100) begin
            if (pushed != bi && bi < nb) begin
                sb_q.push_back({(bi == nb - 1), errmask[bi], mem[8'(a + bi)]});
                pushed = bi;
            end
            bif.RVALID   = (bi < nb);
            bif.OUT      = {mem[8'(a + bi)], errmask[bi]};
            bif.RLAST    = (bi == nb - 1);
            bif.rd_ready = toggle ? !bif.rd_ready : 1'b1;
            #1;
            check("rready", {bif.RREADY, bif.rd_valid}, {bif.rd_ready, bif.RVALID});
            if (bif.rd_valid && bif.rd_ready) begin
                if (sb_q.size() == 0) check("r_underflow", 1, 0);
                else begin
                    e = sb_q.pop_front();
                    check("rbeat", {bif.rd_last, bif.rd_err, bif.rd_data}, e);
                    fin = e[9];
                    popped++;
                end
                bi++;
            end
            @(negedge clk);
            t++;
        end
        bif.RVALID = 0; bif.RLAST = 0; bif.rd_ready = 0;
        check("r_finished", fin, 1);
        check("r_beats", popped, nb);
        check("r_sb_empty", sb_q.size(), 0);
        check("r_done", {bif.done, bif.done_err, bif.cmd_ready}, {1'b1, exp_err, 1'b1});
        @(negedge clk);
        check("r_done_pulse", bif.done, 0);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h5A;
        init_inputs();
        #1 rst = 0;
        #1 check_all_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1;
        #1 check("cmd_ready_release", bif.cmd_ready, 0);
        @(negedge clk);
        check("cmd_ready_after", bif.cmd_ready, 1);

        do_write(8'h10, 4'd3, 4'd5, 8'hA0, 0, 5'h05, 0);
        do_read(8'h10, 4'd3, 4'd5, 4, 16'h0000, 0, 0);
        check("mem_readback", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hA0A1A2A3);
        do_read(8'hFE, 4'd3, 4'd1, 4, 16'h000C, 0, 1);
        do_write(8'h40, 4'd3, 4'd2, 8'h30, 1, 5'h02, 0);
        do_read(8'h40, 4'd3, 4'd2, 4, 16'h0000, 1, 0);
        do_write(8'h50, 4'd1, 4'd5, 8'h77, 0, 5'h07, 1);
        do_write(8'h58, 4'd0, 4'd3, 8'h66, 0, 5'h13, 1);
        do_read(8'h10, 4'd3, 4'd5, 2, 16'h0000, 0, 1);
        do_read(8'h58, 4'd0, 4'd9, 1, 16'h0000, 0, 0);
        do_write(8'h80, 4'd15, 4'd7, 8'hC0, 0, 5'h07, 0);
        do_read(8'h80, 4'd15, 4'd7, 16, 16'h0000, 1, 0);

        issue(1, 8'h20, 4'd3, 4'd1);
        bif.AWREADY = 1;
        @(negedge clk);
        bif.AWREADY = 0; bif.wr_valid = 1; bif.wr_data = 8'h11; bif.WREADY = 0;
        @(negedge clk);
        @(negedge clk);
        check("mid_w_wvalid", {bif.WVALID, bif.WDATA}, 9'h111);
        rst = 0;
        #1 check_all_zero("mid_reset");
        bif.wr_valid = 0;
        repeat (2) begin @(negedge clk); check("mid_reset_nodone", bif.done, 0); end
        rst = 1;
        #1 check("mid_release_ready", bif.cmd_ready, 0);
        @(negedge clk);
        check("mid_ready_after", bif.cmd_ready, 1);
        sb_q.delete();
        do_read(8'h10, 4'd3, 4'd5, 4, 16'h0000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
